// File: rtl/if_fetch_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction-fetch front end.
package if_fetch_pkg;

   localparam logic [31:0] INST_NOP     = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous fetch buffer: registered storage, no bypass, flush clears all entries.
module fetch_fifo
   import if_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push_i,
   input  fetch_entry_t   data_i,
   input  logic           pop_i,
   input  logic           flush_i,
   output fetch_entry_t   head_o,
   output logic [CW-1:0]  count_o,
   output logic           empty_o,
   output logic           full_o
);

   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]            cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + AW'(1);
         end
         if (pop_i) rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests,
// in-order response buffering, jump flush with in-flight discard, NOP injection.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = IF_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        id_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0] outs_q, outs_d, disc_q, disc_d;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty, fifo_full;
   fetch_entry_t  fifo_head, fifo_in;
   logic [31:0]   jump_target;
   logic          accept, drop, push, pop;

   assign jump_target = {jump_addr_i[31:2], 2'b00};
   // Credit counts both buffered words and words still owed by memory, so a push always fits.
   assign imem_req_o  = !rst && !jump_en_i && ((outs_q + fifo_count) < DEPTH_C);
   assign imem_addr_o = pc_q;
   assign accept      = imem_req_o && imem_gnt_i;
   assign drop        = imem_rvalid_i && (disc_q != '0);
   assign push        = imem_rvalid_i && !drop && !jump_en_i;
   assign pop         = inst_valid_o && id_ready_i && !jump_en_i;
   assign fifo_in     = '{addr: resp_pc_q, inst: imem_rdata_i};

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      outs_d    = outs_q;
      disc_d    = disc_q;
      if (jump_en_i) begin
         // Everything still owed by memory after this edge belongs to the old path.
         pc_d      = jump_target;
         resp_pc_d = jump_target;
         outs_d    = outs_q - CW'(imem_rvalid_i);
         disc_d    = outs_d;
      end else begin
         if (accept) pc_d = pc_q + 32'd4;
         if (push)   resp_pc_d = resp_pc_q + 32'd4;
         outs_d = outs_q + CW'(accept) - CW'(imem_rvalid_i);
         if (drop)   disc_d = disc_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outs_q    <= '0;
         disc_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outs_q    <= outs_d;
         disc_q    <= disc_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (fifo_in),
      .pop_i   (pop),
      .flush_i (jump_en_i),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign inst_valid_o = !fifo_empty;
   assign inst_o       = inst_valid_o ? fifo_head.inst : INST_NOP;
   assign inst_addr_o  = inst_valid_o ? fifo_head.addr : ZERO_WORD;

   a_counters: assert property (@(posedge clk) disable iff (rst)
      (disc_q <= outs_q) && (outs_q <= DEPTH_C));
   a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid_i && (outs_q == '0)));
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized bench for if_fetch with a behavioural in-order instruction memory.
module tb_if_fetch;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
   logic [31:0] imem_addr_o, imem_rdata_i;
   logic        jump_en_i, id_ready_i;
   logic [31:0] jump_addr_i, inst_o, inst_addr_o;
   logic        inst_valid_o;

   int n_cmp = 0;
   int n_bad = 0;

   // memory model controls and state
   logic        gnt_en = 1'b1;
   logic        rand_mode = 1'b0;
   logic        rnd_gnt = 1'b0;
   logic        rv_q = 1'b0;
   logic [31:0] rd_q = '0;
   logic [31:0] cyc = '0;
   int          lat = 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
   } mreq_t;
   mreq_t mq[$];

   if_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .id_ready_i    (id_ready_i),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .inst_valid_o  (inst_valid_o)
   );

   always #5 clk = ~clk;

   assign imem_gnt_i    = rand_mode ? rnd_gnt : gnt_en;
   assign imem_rvalid_i = rv_q;
   assign imem_rdata_i  = rd_q;

   // Memory: a grant taken at an edge answers lat cycles later, strictly in order.
   always @(posedge clk) begin
      cyc <= cyc + 32'd1;
      if (rst) mq.delete();
      else begin
         if (imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
         if (imem_req_o && imem_gnt_i)
            mq.push_back({imem_addr_o, cyc + (rand_mode ? $urandom_range(1, 4) : lat)});
      end
   end

   always @(negedge clk) begin
      rnd_gnt <= ($urandom_range(0, 3) != 0);
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         rv_q <= 1'b1;
         rd_q <= mq[0].addr ^ K;
      end else begin
         rv_q <= 1'b0;
         rd_q <= '0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; id_ready_i = 1'b1;
      gnt_en = 1'b1; rand_mode = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Steps cycle by cycle until the head is consumed; ok=0 if the budget runs out.
   task automatic wait_pop(output logic ok, output logic [31:0] a, output logic [31:0] d);
      ok = 1'b0; a = '0; d = '0;
      for (int i = 0; i < 24 && !ok; i++) begin
         if (inst_valid_o && id_ready_i && !jump_en_i) begin
            ok = 1'b1; a = inst_addr_o; d = inst_o;
         end
         @(negedge clk); #2;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); #2;
      n_cmp++;
      if ({imem_req_o, inst_valid_o, inst_o, inst_addr_o} !== {1'b0, 1'b0, NOP, 32'h0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got req=%0b vld=%0b inst=%h addr=%h, want 0 0 %h 0",
                  imem_req_o, inst_valid_o, inst_o, inst_addr_o, NOP);
      end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      n_cmp++;
      if (inst_valid_o !== 1'b1 || imem_addr_o !== 32'h8) begin
         n_bad++;
         $display("FAIL pre_async_reset: got vld=%0b pc=%h, want 1 00000008", inst_valid_o, imem_addr_o);
      end
      rst = 1'b1; #1;
      n_cmp++;
      if ({imem_req_o, inst_valid_o, inst_o, inst_addr_o, imem_addr_o} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
         n_bad++;
         $display("FAIL async_reset: got req=%0b vld=%0b inst=%h addr=%h pc=%h, want 0 0 %h 0 0",
                  imem_req_o, inst_valid_o, inst_o, inst_addr_o, imem_addr_o, NOP);
      end
   endtask

   task automatic test_stream();
      logic ok; logic [31:0] a, d, exp;
      lat = 1;
      do_reset(); #2;
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stream_first_req: got req=%0b addr=%h vld=%0b, want 1 0 0", imem_req_o, imem_addr_o, inst_valid_o);
      end
      @(negedge clk); #2;
      n_cmp++;
      if (imem_addr_o !== 32'h4 || inst_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stream_cycle1: got addr=%h vld=%0b, want 4 0", imem_addr_o, inst_valid_o);
      end
      @(negedge clk); #2;
      n_cmp++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== K) begin
         n_bad++;
         $display("FAIL stream_latency: got vld=%0b addr=%h inst=%h, want 1 0 %h", inst_valid_o, inst_addr_o, inst_o, K);
      end
      exp = 32'h0;
      for (int k = 0; k < 4; k++) begin
         wait_pop(ok, a, d);
         n_cmp++;
         if (ok !== 1'b1 || a !== exp || d !== (exp ^ K)) begin
            n_bad++;
            $display("FAIL stream_order[%0d]: got ok=%0b addr=%h inst=%h, want addr=%h inst=%h", k, ok, a, d, exp, exp ^ K);
         end
         exp += 32'd4;
      end
   endtask

   task automatic test_gnt_stall();
      lat = 1;
      do_reset(); #2;
      @(negedge clk); gnt_en = 1'b0; #2;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            n_bad++;
            $display("FAIL gnt_hold[%0d]: got req=%0b addr=%h, want 1 00000004", i, imem_req_o, imem_addr_o);
         end
         @(negedge clk); #2;
      end
      gnt_en = 1'b1; #1;
      @(negedge clk); #2;
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
         n_bad++;
         $display("FAIL gnt_resume: got req=%0b addr=%h, want 1 00000008", imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_id_stall();
      logic ok; logic [31:0] a, d, exp;
      lat = 1;
      do_reset(); id_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      n_cmp++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin
         n_bad++;
         $display("FAIL stall_head_early: got vld=%0b addr=%h, want 1 0", inst_valid_o, inst_addr_o);
      end
      repeat (2) @(negedge clk);
      #2;
      n_cmp++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== K) begin
         n_bad++;
         $display("FAIL stall_credit_hold: got req=%0b vld=%0b addr=%h inst=%h, want 0 1 0 %h",
                  imem_req_o, inst_valid_o, inst_addr_o, inst_o, K);
      end
      id_ready_i = 1'b1;
      exp = 32'h0;
      for (int k = 0; k < 4; k++) begin
         wait_pop(ok, a, d);
         n_cmp++;
         if (ok !== 1'b1 || a !== exp || d !== (exp ^ K)) begin
            n_bad++;
            $display("FAIL stall_resume[%0d]: got ok=%0b addr=%h inst=%h, want addr=%h inst=%h", k, ok, a, d, exp, exp ^ K);
         end
         exp += 32'd4;
      end
   endtask

   task automatic test_jump_inflight();
      logic ok; logic [31:0] a, d, exp;
      lat = 3;
      do_reset(); #2;
      @(negedge clk);
      @(negedge clk); jump_en_i = 1'b1; jump_addr_i = 32'h102; #2;
      n_cmp++;
      if (imem_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL jump_req_withdrawn: got req=%0b, want 0", imem_req_o);
      end
      @(negedge clk); jump_en_i = 1'b0; #2;
      n_cmp++;
      if (imem_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL jump_pc_reload: got addr=%h vld=%0b, want 00000100 0", imem_addr_o, inst_valid_o);
      end
      exp = 32'h100;
      for (int k = 0; k < 2; k++) begin
         wait_pop(ok, a, d);
         n_cmp++;
         if (ok !== 1'b1 || a !== exp || d !== (exp ^ K)) begin
            n_bad++;
            $display("FAIL jump_discard[%0d]: got ok=%0b addr=%h inst=%h, want addr=%h inst=%h", k, ok, a, d, exp, exp ^ K);
         end
         exp += 32'd4;
      end
   endtask

   task automatic test_jump_rvalid_pop();
      logic ok; logic [31:0] a, d;
      lat = 1;
      do_reset(); #2;
      @(negedge clk);
      @(negedge clk); jump_en_i = 1'b1; jump_addr_i = 32'h200; #2;
      @(negedge clk); jump_en_i = 1'b0; #2;
      n_cmp++;
      if ({inst_valid_o, inst_o, inst_addr_o, imem_req_o, imem_addr_o} !== {1'b0, NOP, 32'h0, 1'b1, 32'h200}) begin
         n_bad++;
         $display("FAIL jump_same_cycle: got vld=%0b inst=%h addr=%h req=%0b pc=%h, want 0 %h 0 1 00000200",
                  inst_valid_o, inst_o, inst_addr_o, imem_req_o, imem_addr_o, NOP);
      end
      wait_pop(ok, a, d);
      n_cmp++;
      if (ok !== 1'b1 || a !== 32'h200 || d !== (32'h200 ^ K)) begin
         n_bad++;
         $display("FAIL jump_same_cycle_next: got ok=%0b addr=%h inst=%h, want 00000200 %h", ok, a, d, 32'h200 ^ K);
      end
   endtask

   task automatic test_back_to_back();
      logic ok; logic [31:0] a, d, exp;
      lat = 2;
      do_reset(); #2;
      @(negedge clk); jump_en_i = 1'b1; jump_addr_i = 32'h300; #2;
      @(negedge clk); jump_addr_i = 32'h400; #2;
      @(negedge clk); jump_en_i = 1'b0; #2;
      n_cmp++;
      if (imem_addr_o !== 32'h400 || imem_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_last_wins: got addr=%h req=%0b vld=%0b, want 00000400 1 0", imem_addr_o, imem_req_o, inst_valid_o);
      end
      exp = 32'h400;
      for (int k = 0; k < 2; k++) begin
         wait_pop(ok, a, d);
         n_cmp++;
         if (ok !== 1'b1 || a !== exp || d !== (exp ^ K)) begin
            n_bad++;
            $display("FAIL b2b_stream[%0d]: got ok=%0b addr=%h inst=%h, want addr=%h inst=%h", k, ok, a, d, exp, exp ^ K);
         end
         exp += 32'd4;
      end
   endtask

   task automatic test_wrap_random();
      logic ok; logic [31:0] a, d, exp, exp_pc, fetch_pc;
      lat = 1;
      do_reset(); jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFF; #2;
      @(negedge clk); jump_en_i = 1'b0; #2;
      n_cmp++;
      if (imem_addr_o !== 32'hFFFF_FFFC || imem_req_o !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_start: got addr=%h req=%0b, want fffffffc 1", imem_addr_o, imem_req_o);
      end
      @(negedge clk); #2;
      n_cmp++;
      if (imem_addr_o !== 32'h0) begin
         n_bad++;
         $display("FAIL wrap_pc: got addr=%h, want 00000000", imem_addr_o);
      end
      exp = 32'hFFFF_FFFC;
      for (int k = 0; k < 3; k++) begin
         wait_pop(ok, a, d);
         n_cmp++;
         if (ok !== 1'b1 || a !== exp || d !== (exp ^ K)) begin
            n_bad++;
            $display("FAIL wrap_stream[%0d]: got ok=%0b addr=%h inst=%h, want addr=%h inst=%h", k, ok, a, d, exp, exp ^ K);
         end
         exp += 32'd4;
      end
      rand_mode = 1'b1;
      exp_pc = '0; fetch_pc = '0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         id_ready_i  = ($urandom_range(0, 3) != 0);
         jump_en_i   = (c == 0) || ($urandom_range(0, 24) == 0);
         jump_addr_i = $urandom;
         #2;
         if (jump_en_i) begin
            n_cmp++;
            if (imem_req_o !== 1'b0) begin
               n_bad++;
               $display("FAIL rnd_jump_req[%0d]: got req=%0b, want 0", c, imem_req_o);
            end
            exp_pc   = {jump_addr_i[31:2], 2'b00};
            fetch_pc = exp_pc;
         end else begin
            if (inst_valid_o && id_ready_i) begin
               n_cmp++;
               if (inst_addr_o !== exp_pc || inst_o !== (exp_pc ^ K)) begin
                  n_bad++;
                  $display("FAIL rnd_pop[%0d]: got addr=%h inst=%h, want addr=%h inst=%h", c, inst_addr_o, inst_o, exp_pc, exp_pc ^ K);
               end
               exp_pc += 32'd4;
            end
            if (imem_req_o && imem_gnt_i) begin
               n_cmp++;
               if (imem_addr_o !== fetch_pc) begin
                  n_bad++;
                  $display("FAIL rnd_fetch[%0d]: got addr=%h, want %h", c, imem_addr_o, fetch_pc);
               end
               fetch_pc += 32'd4;
            end
         end
      end
      @(negedge clk);
      jump_en_i = 1'b0; rand_mode = 1'b0; id_ready_i = 1'b1;
   endtask

   initial begin
      rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; id_ready_i = 1'b1;
      test_reset();
      test_stream();
      test_gnt_stall();
      test_id_stall();
      test_jump_inflight();
      test_jump_rvalid_pop();
      test_back_to_back();
      test_wrap_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
